// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA engine: word width, word type and FSM state encodings.
package dma_controller_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_REQ   = 3'd1,
    DMA_FETCH = 3'd2,
    DMA_WRITE = 3'd3,
    DMA_DONE  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_addr_counter.sv
// Holds the block base, word count and length; produces the current write
// address (wrapping modulo 2^WORD_SIZE) and a flag for the final word.
module dma_addr_counter
  import dma_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 inc,
  input  logic [WORD_SIZE-1:0] base_in,
  input  logic [WORD_SIZE-1:0] len_in,
  output logic [WORD_SIZE-1:0] mem_address2,
  output logic                 last
);

  word_t base;
  word_t len;
  word_t count;

  // Block registers: load restarts the count, inc advances one word.
  always_ff @(posedge clk) begin
    if (reset) begin
      base  <= '0;
      len   <= '0;
      count <= '0;
    end else if (load) begin
      base  <= base_in;
      len   <= len_in;
      count <= '0;
    end else if (inc) begin
      count <= count + word_t'(1);
    end else begin
      count <= count;
    end
  end

  assign mem_address2 = base + count;
  assign last         = ((count + word_t'(1)) == len);

endmodule

// File: rtl/dma_controller.sv
// Bus-mastering DMA engine: requests the bus, then copies a block of device
// words into memory port 2 while the grant is held, and pulses dma_end.
module dma_controller
  import dma_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 begin_dma,
  input  logic [WORD_SIZE-1:0] target_address,
  input  logic [WORD_SIZE-1:0] length,
  input  logic                 bg,
  output logic                 br,
  output logic                 dma_end,
  output logic                 busy,
  input  logic                 dev_valid,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 dev_ready,
  input  logic                 mem_ack,
  output logic                 write_m2,
  output logic [WORD_SIZE-1:0] mem_address2,
  output logic [WORD_SIZE-1:0] mem_write_data
);

  dma_state_e state;
  dma_state_e next_state;
  word_t      data_reg;
  logic       load;
  logic       inc;
  logic       capture;
  logic       last;

  dma_addr_counter u_addr_counter (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .inc          (inc),
    .base_in      (target_address),
    .len_in       (length),
    .mem_address2 (mem_address2),
    .last         (last)
  );

  // State register and device word capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DMA_IDLE;
      data_reg <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        data_reg <= dev_data;
      end else begin
        data_reg <= data_reg;
      end
    end
  end

  // Next-state and output decode; handshake strobes are gated by bg so the
  // port never writes or accepts data without the bus.
  always_comb begin
    next_state = state;
    br         = 1'b0;
    dma_end    = 1'b0;
    dev_ready  = 1'b0;
    write_m2   = 1'b0;
    load       = 1'b0;
    inc        = 1'b0;
    capture    = 1'b0;
    case (state)
      DMA_IDLE: begin
        if (begin_dma) begin
          load       = 1'b1;
          next_state = (length == '0) ? DMA_DONE : DMA_REQ;
        end else begin
          next_state = DMA_IDLE;
        end
      end
      DMA_REQ: begin
        br = 1'b1;
        if (bg) begin
          next_state = DMA_FETCH;
        end else begin
          next_state = DMA_REQ;
        end
      end
      DMA_FETCH: begin
        br        = 1'b1;
        dev_ready = bg;
        if (!bg) begin
          next_state = DMA_REQ;
        end else if (dev_valid) begin
          capture    = 1'b1;
          next_state = DMA_WRITE;
        end else begin
          next_state = DMA_FETCH;
        end
      end
      DMA_WRITE: begin
        br       = 1'b1;
        write_m2 = bg;
        if (bg && mem_ack) begin
          inc        = 1'b1;
          next_state = last ? DMA_DONE : DMA_FETCH;
        end else begin
          next_state = DMA_WRITE;
        end
      end
      DMA_DONE: begin
        dma_end    = 1'b1;
        next_state = DMA_IDLE;
      end
      default: begin
        next_state = DMA_IDLE;
      end
    endcase
  end

  assign busy           = (state != DMA_IDLE);
  assign mem_write_data = data_reg;

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: table-driven transfers, randomized
// transfers against a block-copy reference, and a mid-transfer reset sequence.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        begin_dma;
  logic [15:0] target_address;
  logic [15:0] length;
  logic        bg;
  logic        br;
  logic        dma_end;
  logic        busy;
  logic        dev_valid;
  logic [15:0] dev_data;
  logic        dev_ready;
  logic        mem_ack;
  logic        write_m2;
  logic [15:0] mem_address2;
  logic [15:0] mem_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  dma_controller dut (
    .clk            (clk),
    .reset          (reset),
    .begin_dma      (begin_dma),
    .target_address (target_address),
    .length         (length),
    .bg             (bg),
    .br             (br),
    .dma_end        (dma_end),
    .busy           (busy),
    .dev_valid      (dev_valid),
    .dev_data       (dev_data),
    .dev_ready      (dev_ready),
    .mem_ack        (mem_ack),
    .write_m2       (write_m2),
    .mem_address2   (mem_address2),
    .mem_write_data (mem_write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    int          gap;
    int          ack_lat;
    int          drop_at;
    bit          extra;
    int          exp_writes;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    begin_dma      = 1'b0;
    target_address = 16'h0000;
    length         = 16'h0000;
    bg             = 1'b0;
    dev_valid      = 1'b0;
    dev_data       = 16'h0000;
    mem_ack        = 1'b0;
  endtask

  // One complete transfer with a reactive CPU/device/memory environment.
  // Reference: the block copy writes words[i] to (b + i) mod 2^16, in order.
  task automatic run_transfer(input string tag, input logic [15:0] b, input logic [15:0] n,
                              input int gap, input int ack_lat, input int drop_at, input bit extra,
                              output int nwrites, output logic [15:0] first_a, output logic [15:0] last_a);
    logic [15:0] words[$];
    logic [15:0] w;
    logic [15:0] exp_a;
    bit br_prev = 1'b0, dropped = 1'b0, done = 1'b0;
    int drop_cnt = 0, dev_wait = gap, dev_idx = 0, wcount = 0, wr_cycles = 0, hs = 0, viol = 0;
    first_a = 16'h0000;
    last_a  = 16'h0000;
    for (int i = 0; i < int'(n); i++) begin
      w = 16'($urandom);
      words.push_back(w);
    end
    @(negedge clk);
    begin_dma = 1'b1; target_address = b; length = n;
    bg = 1'b0; dev_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      bg        = br_prev && (drop_cnt == 0);
      dev_valid = (dev_wait == 0) && (dev_idx < int'(n));
      dev_data  = dev_valid ? words[dev_idx] : 16'($urandom);
      mem_ack   = (wr_cycles >= ack_lat) || (drop_cnt > 0);
      begin_dma = extra && (cyc == 5);
      target_address = 16'($urandom);
      length         = 16'($urandom_range(1, 9));
      #1;
      if (cyc == 1) begin
        check({tag, "_br_start"}, 64'(br), 64'(n != 16'd0));
        check({tag, "_end_start"}, 64'(dma_end), 64'(n == 16'd0));
      end
      if (write_m2 && !bg) viol++;
      if (dev_ready && !bg) viol++;
      if ((n == 16'd0) && (br || write_m2 || dev_ready)) viol++;
      if (dev_ready && dev_valid) begin
        hs++; dev_idx++; dev_wait = gap;
      end else if (dev_wait > 0) begin
        dev_wait--;
      end
      if (drop_cnt > 0) begin
        drop_cnt--;
      end else if (write_m2 && (wcount == drop_at) && !dropped) begin
        drop_cnt = 3; dropped = 1'b1;
      end
      if (write_m2) begin
        exp_a = b + 16'(wcount);
        check($sformatf("%s_wr%0d_addr", tag, wcount), 64'(mem_address2), 64'(exp_a));
        if (wcount < int'(n)) begin
          check($sformatf("%s_wr%0d_data", tag, wcount), 64'(mem_write_data), 64'(words[wcount]));
        end else begin
          check($sformatf("%s_extra_write", tag), 64'(wcount), 64'(n));
        end
        if (mem_ack) begin
          if (wcount == 0) first_a = mem_address2;
          last_a = mem_address2;
          wcount++; wr_cycles = 0;
        end else begin
          wr_cycles++;
        end
      end
      if (dma_end) begin
        check({tag, "_end_br"}, 64'(br), 64'd0);
        check({tag, "_end_busy"}, 64'(busy), 64'd1);
        check({tag, "_writes"}, 64'(wcount), 64'(n));
        check({tag, "_handshakes"}, 64'(hs), 64'(n));
        done = 1'b1;
      end
      br_prev = br;
      @(negedge clk);
    end
    check({tag, "_completed"}, 64'(done), 64'd1);
    check({tag, "_bus_rules"}, 64'(viol), 64'd0);
    idle_inputs();
    #1;
    check({tag, "_busy_fall"}, 64'({busy, dma_end}), 64'd0);
    nwrites = wcount;
  endtask

  initial begin
    int          nw;
    logic [15:0] fa, la;
    bit          hit;

    vecs[0] = '{16'h000B, 16'd12, 0, 2, -1, 1'b0, 12, 16'h000B, 16'h0016};
    vecs[1] = '{16'h1234, 16'd0,  0, 2, -1, 1'b0, 0,  16'h0000, 16'h0000};
    vecs[2] = '{16'h000B, 16'd12, 0, 2,  4, 1'b0, 12, 16'h000B, 16'h0016};
    vecs[3] = '{16'h0100, 16'd5,  4, 1, -1, 1'b0, 5,  16'h0100, 16'h0104};
    vecs[4] = '{16'hFFFE, 16'd4,  0, 0, -1, 1'b1, 4,  16'hFFFE, 16'h0001};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_outputs", {br, dma_end, busy, dev_ready, write_m2, mem_address2, mem_write_data}, 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_transfer($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, vecs[i].gap,
                   vecs[i].ack_lat, vecs[i].drop_at, vecs[i].extra, nw, fa, la);
      check($sformatf("vec%0d_count", i), 64'(nw), 64'(vecs[i].exp_writes));
      if (vecs[i].exp_writes > 0) begin
        check($sformatf("vec%0d_first", i), 64'(fa), 64'(vecs[i].exp_first));
        check($sformatf("vec%0d_last", i), 64'(la), 64'(vecs[i].exp_last));
      end
    end

    for (int r = 0; r < 20; r++) begin
      run_transfer($sformatf("rnd%0d", r), 16'($urandom), 16'($urandom_range(0, 8)),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : -1, 1'b0, nw, fa, la);
    end

    // Reset while a write is pending, then a clean restart.
    @(negedge clk);
    begin_dma = 1'b1; target_address = 16'h0040; length = 16'd6;
    @(negedge clk);
    begin_dma = 1'b0; bg = 1'b1; dev_valid = 1'b1; dev_data = 16'hBEEF; mem_ack = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      #1;
      if (write_m2) hit = 1'b1;
      else @(negedge clk);
    end
    check("rst_reached_write", 64'(hit), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_outputs", {br, dma_end, busy, dev_ready, write_m2, mem_address2, mem_write_data}, 64'd0);
    idle_inputs();
    run_transfer("after_rst", 16'h0200, 16'd3, 0, 1, -1, 1'b0, nw, fa, la);
    check("after_rst_first", 64'(fa), 64'h0200);
    check("after_rst_last", 64'(la), 64'h0202);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_controller.md
# dma_controller

Bus-mastering DMA engine at the device end of the CPU's DMA handshake. When the CPU pulses `begin_dma`, the engine latches the target address and length, then requests the memory bus with `br` and waits for `bg`. While it holds the bus it moves `length` words from the external device buffer into memory port 2, one word at a time. At the end it pulses `dma_end` so the CPU can reclaim the bus. It sits beside the cache/memory subsystem and drives the memory port 2 write path only while granted.

## Interface
- `WORD_SIZE`, 16, data/address width
- `clk` input 1: single clock; all state changes on rising edge
- `reset` input 1: synchronous, active-high
- `begin_dma` input 1: one-cycle start pulse from CPU
- `target_address` input WORD_SIZE: base memory address, sampled with `begin_dma`
- `length` input WORD_SIZE: word count, sampled with `begin_dma`
- `bg` input 1: bus grant from CPU
- `br` output 1: bus request
- `dma_end` output 1: one-cycle completion pulse
- `busy` output 1: high from the cycle after an accepted `begin_dma` through the `dma_end` cycle
- `dev_valid` input 1: device has a word on `dev_data`
- `dev_data` input WORD_SIZE: device word
- `dev_ready` output 1: engine accepts a device word this cycle
- `mem_ack` input 1: memory has completed the current write (one-cycle pulse)
- `write_m2` output 1: memory port 2 write strobe
- `mem_address2` output WORD_SIZE: write address
- `mem_write_data` output WORD_SIZE: write data

## Operation
- States: IDLE, REQ, FETCH, WRITE, DONE.
- IDLE: if `begin_dma`=1, latch `base`←`target_address`, `len`←`length`, `count`←0. If `length`=0, go to DONE without asserting `br`; otherwise go to REQ.
- REQ: `br`=1. If `bg`=1, go to FETCH; otherwise stay in REQ.
- FETCH: `br`=1 and `dev_ready`=`bg`. On `dev_valid`&`dev_ready`, capture `dev_data` into the data register and go to WRITE. If `bg`=0, go to REQ with `count` preserved.
- WRITE: `br`=1 and `write_m2`=`bg`. `mem_address2` = `base`+`count`, modulo 2^WORD_SIZE. `mem_write_data` is the data register, held stable.
  - If `mem_ack`=1 while `bg`=1: `count`←`count`+1. If the new `count`=`len`, go to DONE; otherwise go to FETCH.
  - If `bg`=0, `write_m2` drops and `mem_ack` is ignored. The state stays WRITE with data held, and the write reissues when `bg` returns.
- DONE: `br`=0 and `dma_end`=1 for exactly one cycle, then IDLE.
- `begin_dma` is ignored in every state except IDLE. No queuing.
- `mem_ack` is ignored outside WRITE. `dev_valid` is ignored when `dev_ready`=0.
- Reset: state→IDLE; `count`, `len`, `base` and the data register → 0. All outputs are 0 after the reset edge, including mid-transfer. A partially written block is abandoned.

## Timing
- Reset values: `br`, `dma_end`, `busy`, `dev_ready`, `write_m2` = 0; `mem_address2`, `mem_write_data` = 0.
- `begin_dma` sampled at edge N → `br`=1 in cycle N+1.
- `bg` sampled high in REQ at edge M → `dev_ready`=1 in cycle M+1.
- Device handshake at edge K → `write_m2`=1 in cycle K+1, with address and data valid in the same cycle.
- `mem_ack` at edge A on the last word → `dma_end`=1 and `br`=0 in cycle A+1. `busy` falls in cycle A+2.
- Minimum per word: 2 cycles (FETCH + WRITE) plus memory latency.
- Address/data outputs change only on state entry or `count` increment. `write_m2` must never be high while `bg`=0.
- `length`=0: `dma_end` pulses in the cycle after `begin_dma`, and `br` is never raised.
- Address wrap: base 0xFFFE, length 4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.

## Structure
- The shared defines header supplies `WORD_SIZE` and the state encodings (`DMA_IDLE`, `DMA_REQ`, `DMA_FETCH`, `DMA_WRITE`, `DMA_DONE`).
- One sub-module, `dma_addr_counter`, holds `base`, `count` and `len`. It has load and increment controls and outputs `mem_address2` and `last` (`count`+1=`len`).
- FSM, data register and output decode live in the top level.

## Test plan
- Basic transfer: `begin_dma` with address 0x000B, length 12; `bg` granted 1 cycle after `br`; device always valid; `mem_ack` 2 cycles after each write → exactly 12 writes to 0x000B–0x0016 with device data in order, then one `dma_end` pulse with `br`=0.
- Zero length: `begin_dma` with length 0 → `dma_end` in the next cycle; `br`, `write_m2` and `dev_ready` stay 0.
- Grant withdrawal: drop `bg` for 3 cycles during the 5th WRITE → `write_m2` is 0 while `bg`=0; the same address and data reissue afterwards; total writes = 12, with no skipped or duplicated address.
- Slow device: `dev_valid` low for 4 cycles before each word → `dev_ready` held and no `write_m2` until the handshake; data order preserved.
- Busy rejection and wrap: a second `begin_dma` during the transfer is ignored; base 0xFFFE, length 4 → addresses wrap to 0x0000 and 0x0001.
- Reset mid-transfer: assert `reset` in WRITE → all outputs 0 after the edge. A following `begin_dma` starts cleanly at `count`=0.
